plot_shadow_buffer: RTL and testbench

Receiving end of the pixel-plot interface (x, y, colour, plot) that drives the VGA adapter. The block snoops the same plot bus in parallel with the adapter and keeps a 160x120, 3-bit shadow copy of the framebuffer. It provides a pipelined read port for game logic (collision checks, readback), a hardware clear sequencer, and plot/drop counters for debug on the HEX displays.

---
 rtl/plot_shadow_buffer.sv | 220 ++++++++++++++++++++++
 tb/tb_plot_shadow_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/plot_shadow_buffer.sv
// Shadow copy of the 160x120x3 VGA framebuffer, fed by snooping the plot bus.
// Two-cycle read port with write forwarding, a zero-fill sequencer and debug counters.
//
// state    | meaning
// ST_IDLE  | plots written, clear may start
// ST_CLEAR | zero written to one address per cycle, plots dropped, reads return 0
module plot_shadow_buffer #(
   parameter int WIDTH  = 160,
   parameter int HEIGHT = 120,
   parameter int CW     = 3
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic [7:0]    x,
   input  logic [6:0]    y,
   input  logic [CW-1:0] colour,
   input  logic          plot,
   input  logic          rd_req,
   input  logic [7:0]    rd_x,
   input  logic [6:0]    rd_y,
   output logic          rd_valid,
   output logic [CW-1:0] rd_colour,
   input  logic          clear,
   output logic          busy,
   output logic [15:0]   plot_count,
   output logic [7:0]    drop_count
);

   localparam int              AW        = 15;
   localparam int              DEPTH     = WIDTH * HEIGHT;
   localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [7:0]      X_LIM     = 8'(WIDTH);
   localparam logic [6:0]      Y_LIM     = 7'(HEIGHT);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // y*160 + x, built from shifts so no multiplier is needed
   function automatic logic [AW-1:0] lin_addr(input logic [7:0] col, input logic [6:0] row);
      logic [AW-1:0] r;
      r = {{(AW-7){1'b0}}, row};
      return (r << 7) + (r << 5) + {{(AW-8){1'b0}}, col};
   endfunction

   state_t          state_q, state_d;
   logic            busy_q, busy_d;
   logic [AW-1:0]   clr_addr_q, clr_addr_d;

   logic            w1_valid_q, w1_valid_d;
   logic [AW-1:0]   w1_addr_q, w1_addr_d;
   logic [CW-1:0]   w1_data_q, w1_data_d;
   logic            acc1_q, acc1_d;
   logic            drop1_q, drop1_d;
   logic [15:0]     plot_count_q, plot_count_d;
   logic [7:0]      drop_count_q, drop_count_d;

   logic            r1_valid_q, r1_valid_d;
   logic            r1_zero_q, r1_zero_d;
   logic [AW-1:0]   r1_addr_q, r1_addr_d;
   logic            r2_valid_q, r2_valid_d;
   logic            r2_zero_q, r2_zero_d;
   logic            r2_fwd_q, r2_fwd_d;
   logic [CW-1:0]   r2_fwd_data_q, r2_fwd_data_d;
   logic            rd_valid_q, rd_valid_d;
   logic [CW-1:0]   rd_colour_q, rd_colour_d;

   logic [CW-1:0]   mem [DEPTH];
   logic [CW-1:0]   ram_rdata_q;
   logic            ram_we;
   logic [AW-1:0]   ram_waddr;
   logic [CW-1:0]   ram_wdata;

   logic            clr_active;
   logic            start_clr;
   logic            plot_in_rng;
   logic            plot_ok;
   logic            rd_in_rng;

   always_comb begin
      state_d       = state_q;
      clr_addr_d    = clr_addr_q;
      busy_d        = (state_q == ST_CLEAR);

      // busy lags the state by a cycle; both windows count as "clearing"
      clr_active    = (state_q == ST_CLEAR) || busy_q;
      start_clr     = (state_q == ST_IDLE) && clear;
      plot_in_rng   = (x < X_LIM) && (y < Y_LIM);
      plot_ok       = plot && plot_in_rng && !clr_active && !start_clr;
      rd_in_rng     = (rd_x < X_LIM) && (rd_y < Y_LIM);

      case (state_q)
         ST_IDLE: begin
            if (clear) begin
               state_d    = ST_CLEAR;
               clr_addr_d = '0;
            end
         end
         ST_CLEAR: begin
            if (clr_addr_q == LAST_ADDR) begin
               state_d    = ST_IDLE;
               clr_addr_d = '0;
            end else begin
               clr_addr_d = clr_addr_q + AW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      w1_valid_d    = plot_ok;
      w1_addr_d     = lin_addr(x, y);
      w1_data_d     = colour;
      acc1_d        = plot_ok;
      drop1_d       = plot && !plot_ok;

      plot_count_d  = plot_count_q;
      if (acc1_q) begin
         plot_count_d = plot_count_q + 16'd1;
      end
      drop_count_d  = drop_count_q;
      if (drop1_q && (drop_count_q != 8'hFF)) begin
         drop_count_d = drop_count_q + 8'd1;
      end

      r1_valid_d    = rd_req;
      r1_zero_d     = !rd_in_rng || clr_active;
      r1_addr_d     = rd_in_rng ? lin_addr(rd_x, rd_y) : '0;

      // a plot sampled together with the read lands in RAM on the read edge
      r2_valid_d    = r1_valid_q;
      r2_zero_d     = r1_zero_q;
      r2_fwd_d      = w1_valid_q && (w1_addr_q == r1_addr_q);
      r2_fwd_data_d = w1_data_q;

      rd_valid_d    = r2_valid_q;
      rd_colour_d   = rd_colour_q;
      if (r2_valid_q) begin
         if (r2_zero_q) begin
            rd_colour_d = '0;
         end else if (r2_fwd_q) begin
            rd_colour_d = r2_fwd_data_q;
         end else begin
            rd_colour_d = ram_rdata_q;
         end
      end

      ram_we        = 1'b0;
      ram_waddr     = w1_addr_q;
      ram_wdata     = w1_data_q;
      if (Resetn) begin
         if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = '0;
         end else if (w1_valid_q) begin
            ram_we    = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q       <= ST_IDLE;
         busy_q        <= 1'b0;
         clr_addr_q    <= '0;
         w1_valid_q    <= 1'b0;
         w1_addr_q     <= '0;
         w1_data_q     <= '0;
         acc1_q        <= 1'b0;
         drop1_q       <= 1'b0;
         plot_count_q  <= '0;
         drop_count_q  <= '0;
         r1_valid_q    <= 1'b0;
         r1_zero_q     <= 1'b0;
         r1_addr_q     <= '0;
         r2_valid_q    <= 1'b0;
         r2_zero_q     <= 1'b0;
         r2_fwd_q      <= 1'b0;
         r2_fwd_data_q <= '0;
         rd_valid_q    <= 1'b0;
         rd_colour_q   <= '0;
      end else begin
         state_q       <= state_d;
         busy_q        <= busy_d;
         clr_addr_q    <= clr_addr_d;
         w1_valid_q    <= w1_valid_d;
         w1_addr_q     <= w1_addr_d;
         w1_data_q     <= w1_data_d;
         acc1_q        <= acc1_d;
         drop1_q       <= drop1_d;
         plot_count_q  <= plot_count_d;
         drop_count_q  <= drop_count_d;
         r1_valid_q    <= r1_valid_d;
         r1_zero_q     <= r1_zero_d;
         r1_addr_q     <= r1_addr_d;
         r2_valid_q    <= r2_valid_d;
         r2_zero_q     <= r2_zero_d;
         r2_fwd_q      <= r2_fwd_d;
         r2_fwd_data_q <= r2_fwd_data_d;
         rd_valid_q    <= rd_valid_d;
         rd_colour_q   <= rd_colour_d;
      end
   end

   // storage is deliberately not reset; an aborted clear leaves it partially zeroed
   always_ff @(posedge Clock) begin
      if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
      end
      ram_rdata_q <= mem[r1_addr_q];
   end

   assign busy       = busy_q;
   assign rd_valid   = rd_valid_q;
   assign rd_colour  = rd_colour_q;
   assign plot_count = plot_count_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_plot_shadow_buffer.sv
// Directed bench for plot_shadow_buffer: write/read, forwarding hazards, range drops,
// clear sequencing, reset mid-clear and plot counter wrap.
module tb_plot_shadow_buffer;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        plot;
   logic        rd_req;
   logic [7:0]  rd_x;
   logic [6:0]  rd_y;
   logic        rd_valid;
   logic [2:0]  rd_colour;
   logic        clear;
   logic        busy;
   logic [15:0] plot_count;
   logic [7:0]  drop_count;

   int n_cmp = 0;
   int n_bad = 0;
   int n;

   plot_shadow_buffer dut (
      .Clock      (Clock),
      .Resetn     (Resetn),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .plot       (plot),
      .rd_req     (rd_req),
      .rd_x       (rd_x),
      .rd_y       (rd_y),
      .rd_valid   (rd_valid),
      .rd_colour  (rd_colour),
      .clear      (clear),
      .busy       (busy),
      .plot_count (plot_count),
      .drop_count (drop_count)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   task automatic step(input logic p, input logic [7:0] px, input logic [6:0] py,
                       input logic [2:0] pc, input logic r, input logic [7:0] rx,
                       input logic [6:0] ry);
      plot   = p;
      x      = px;
      y      = py;
      colour = pc;
      rd_req = r;
      rd_x   = rx;
      rd_y   = ry;
      cyc();
      plot   = 1'b0;
      rd_req = 1'b0;
   endtask

   task automatic plot_px(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
      step(1'b1, px, py, pc, 1'b0, 8'd0, 7'd0);
   endtask

   task automatic read_chk(input string tag, input logic [7:0] rx, input logic [6:0] ry,
                           input logic [2:0] exp);
      step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, rx, ry);
      cyc();
      chk({tag, "_early"}, 32'(rd_valid), 0);
      cyc();
      chk({tag, "_valid"}, 32'(rd_valid), 1);
      chk(tag, 32'(rd_colour), 32'(exp));
   endtask

   task automatic reset_dut();
      Resetn = 1'b0;
      repeat (2) cyc();
      Resetn = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Resetn = 1'b0;
      plot = 1'b0; rd_req = 1'b0; clear = 1'b0;
      x = 8'd0; y = 7'd0; colour = 3'd0; rd_x = 8'd0; rd_y = 7'd0;
      repeat (3) cyc();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_colour", 32'(rd_colour), 0);
      chk("rst_plot_count", 32'(plot_count), 0);
      chk("rst_drop_count", 32'(drop_count), 0);
      Resetn = 1'b1;
      cyc();

      // plot then read on the following cycle
      plot_px(8'd5, 7'd3, 3'b101);
      step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 8'd5, 7'd3);
      chk("wr_plot_count", 32'(plot_count), 1);
      cyc();
      chk("wr_rd_early", 32'(rd_valid), 0);
      cyc();
      chk("wr_rd_valid", 32'(rd_valid), 1);
      chk("wr_rd_colour", 32'(rd_colour), 5);

      // plot and read of the same pixel in the same cycle
      step(1'b1, 8'd159, 7'd119, 3'b010, 1'b1, 8'd159, 7'd119);
      cyc();
      cyc();
      chk("same_cyc_valid", 32'(rd_valid), 1);
      chk("same_cyc_colour", 32'(rd_colour), 2);

      // back-to-back plots to (0,0), read alongside the second
      plot_px(8'd0, 7'd0, 3'd1);
      step(1'b1, 8'd0, 7'd0, 3'd6, 1'b1, 8'd0, 7'd0);
      cyc();
      cyc();
      chk("b2b_valid", 32'(rd_valid), 1);
      chk("b2b_colour", 32'(rd_colour), 6);

      // a plot after the read must not leak into it
      step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 8'd0, 7'd0);
      plot_px(8'd0, 7'd0, 3'd3);
      cyc();
      chk("late_plot_valid", 32'(rd_valid), 1);
      chk("late_plot_colour", 32'(rd_colour), 6);
      read_chk("late_plot_after", 8'd0, 7'd0, 3'd3);
      chk("b2b_plot_count", 32'(plot_count), 5);

      // out-of-range plots; (160,0) would alias (0,1) if it were written
      plot_px(8'd0, 7'd1, 3'd4);
      plot_px(8'd160, 7'd0, 3'd7);
      plot_px(8'd0, 7'd120, 3'd7);
      cyc();
      chk("oor_drop_count", 32'(drop_count), 2);
      chk("oor_plot_count", 32'(plot_count), 6);
      read_chk("oor_alias", 8'd0, 7'd1, 3'd4);
      read_chk("oor_read", 8'd200, 7'd5, 3'd0);

      plot = 1'b1; x = 8'd200; y = 7'd5; colour = 3'd7;
      repeat (300) cyc();
      plot = 1'b0;
      cyc();
      chk("drop_saturate", 32'(drop_count), 255);
      chk("drop_sat_plot_count", 32'(plot_count), 6);

      // reset 500 cycles into a clear, with a read in flight
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      repeat (499) cyc();
      chk("midclr_busy_before", 32'(busy), 1);
      step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 8'd5, 7'd3);
      Resetn = 1'b0;
      cyc();
      chk("midclr_busy", 32'(busy), 0);
      chk("midclr_plot_count", 32'(plot_count), 0);
      chk("midclr_drop_count", 32'(drop_count), 0);
      chk("midclr_rd_valid", 32'(rd_valid), 0);
      Resetn = 1'b1;
      cyc();
      chk("midclr_rd_valid_after", 32'(rd_valid), 0);
      chk("midclr_busy_after", 32'(busy), 0);

      // full clear with a drop and a read while busy
      plot_px(8'd10, 7'd10, 3'd7);
      read_chk("pre_clear", 8'd10, 7'd10, 3'd7);
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      chk("clr_busy_lag", 32'(busy), 0);
      x = 8'd20; y = 7'd20; colour = 3'd5;
      rd_x = 8'd10; rd_y = 7'd10;
      cyc();
      n = 0;
      while (busy && n < 20000) begin
         n++;
         if (n == 203) begin
            chk("clr_rd_valid", 32'(rd_valid), 1);
            chk("clr_rd_colour", 32'(rd_colour), 0);
         end
         plot   = (n == 100);
         rd_req = (n == 200);
         cyc();
      end
      plot = 1'b0;
      rd_req = 1'b0;
      chk("clr_busy_cycles", 32'(n), 19200);
      chk("clr_drop_count", 32'(drop_count), 1);
      chk("clr_plot_count", 32'(plot_count), 1);
      plot_px(8'd20, 7'd20, 3'd5);
      cyc();
      chk("post_clr_plot_count", 32'(plot_count), 2);
      read_chk("post_clr_plot", 8'd20, 7'd20, 3'd5);
      read_chk("post_clr_10_10", 8'd10, 7'd10, 3'd0);
      read_chk("post_clr_159_119", 8'd159, 7'd119, 3'd0);

      // plot counter wrap
      reset_dut();
      plot = 1'b1; colour = 3'd1;
      for (int i = 0; i < 65535; i++) begin
         x = 8'(i % 160);
         y = 7'((i / 160) % 120);
         cyc();
      end
      plot = 1'b0;
      cyc();
      chk("wrap_65535", 32'(plot_count), 65535);
      plot_px(8'd1, 7'd1, 3'd2);
      cyc();
      chk("wrap_zero", 32'(plot_count), 0);
      chk("wrap_drop_count", 32'(drop_count), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
